ir_nec_tx: RTL and testbench

IR_NEC_TX -- requirements
Module: ir_nec_tx

---
 rtl/ir_nec_tx.sv | 156 +++++++++++++++
 tb/tb_ir_nec_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_tx.sv
// NEC infrared frame transmitter.
// Sends lead mark/space, 32 data bits (addr, ~addr, cmd, ~cmd, each LSB first),
// a stop mark and an enforced low gap. ir_out is the baseband envelope.
// ir_mod is that envelope gated by a free-running carrier square wave.
module ir_nec_tx #(
  parameter int CLK_PER_TICK = 3500,
  parameter int CARRIER_HALF = 1316,
  parameter int GAP_TICKS    = 64
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ir_out,
  output logic       ir_mod
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(CLK_PER_TICK - 1);
  localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_HALF - 1);

  localparam logic [15:0] LEAD_MARK_T  = 16'd256;
  localparam logic [15:0] LEAD_SPACE_T = 16'd128;
  localparam logic [15:0] BIT_T        = 16'd16;
  localparam logic [15:0] ONE_SPACE_T  = 16'd48;
  localparam logic [15:0] GAP_T        = 16'(GAP_TICKS);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LEAD_MARK  = 3'd1;
  localparam logic [2:0] S_LEAD_SPACE = 3'd2;
  localparam logic [2:0] S_BIT_MARK   = 3'd3;
  localparam logic [2:0] S_BIT_SPACE  = 3'd4;
  localparam logic [2:0] S_STOP_MARK  = 3'd5;
  localparam logic [2:0] S_GAP        = 3'd6;

  logic [2:0]    state;
  logic [PW-1:0] prescale;
  logic [15:0]   tick_cnt;
  logic [5:0]    bit_cnt;
  logic [31:0]   shreg;
  logic [CW-1:0] car_cnt;
  logic          carrier;
  logic [15:0]   seg_len;
  logic          seg_end;

  // Length in ticks of the segment the current state represents
  always_comb begin
    seg_len = 16'd1;
    case (state)
      S_LEAD_MARK:  seg_len = LEAD_MARK_T;
      S_LEAD_SPACE: seg_len = LEAD_SPACE_T;
      S_BIT_MARK:   seg_len = BIT_T;
      S_BIT_SPACE:  seg_len = shreg[0] ? ONE_SPACE_T : BIT_T;
      S_STOP_MARK:  seg_len = BIT_T;
      S_GAP:        seg_len = GAP_T;
      default:      seg_len = 16'd1;
    endcase
  end

  assign seg_end = (state != S_IDLE) && (prescale == PS_LAST) &&
                   (tick_cnt == seg_len - 16'd1);

  // Tick prescaler and per-segment tick counter, both restarted on every state change
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      tick_cnt <= '0;
    end else if (state == S_IDLE || seg_end) begin
      prescale <= '0;
      tick_cnt <= '0;
    end else if (prescale == PS_LAST) begin
      prescale <= '0;
      tick_cnt <= tick_cnt + 16'd1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // Frame sequencer; ir_out, tx_busy and tx_done are registered here
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      ir_out  <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // a start coinciding with the done pulse is dropped
          if (tx_start && !tx_done) begin
            shreg   <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
            bit_cnt <= '0;
            state   <= S_LEAD_MARK;
            ir_out  <= 1'b1;
            tx_busy <= 1'b1;
          end
        end
        S_LEAD_MARK: if (seg_end) begin
          state  <= S_LEAD_SPACE;
          ir_out <= 1'b0;
        end
        S_LEAD_SPACE: if (seg_end) begin
          state  <= S_BIT_MARK;
          ir_out <= 1'b1;
        end
        S_BIT_MARK: if (seg_end) begin
          state  <= S_BIT_SPACE;
          ir_out <= 1'b0;
        end
        S_BIT_SPACE: if (seg_end) begin
          shreg   <= {1'b0, shreg[31:1]};
          bit_cnt <= bit_cnt + 6'd1;
          ir_out  <= 1'b1;
          state   <= (bit_cnt == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
        S_STOP_MARK: if (seg_end) begin
          state  <= S_GAP;
          ir_out <= 1'b0;
        end
        S_GAP: if (seg_end) begin
          state   <= S_IDLE;
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ir_out  <= 1'b0;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Free-running carrier divider, toggles every CARRIER_HALF cycles
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      car_cnt <= '0;
      carrier <= 1'b0;
    end else if (car_cnt == CAR_LAST) begin
      car_cnt <= '0;
      carrier <= ~carrier;
    end else begin
      car_cnt <= car_cnt + 1'b1;
    end
  end

  assign ir_mod = ir_out & carrier;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: table of directed frames, randomized frames and
// multi-cycle corner cases, all compared against a segment-list model.
module tb_ir_nec_tx;

  localparam int CPT = 2;
  localparam int CH  = 3;
  localparam int GAP = 5;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_addr = 8'h00;
  logic [7:0] tx_cmd = 8'h00;
  logic       tx_busy, tx_done, ir_out, ir_mod;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int mod_errs = 0;
  int exp_q[$];
  int meas_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] cmd;
    logic [7:0] exp_a;
    logic [7:0] exp_c;
  } vec_t;
  vec_t vecs[5];

  always #5 clk_in = ~clk_in;

  ir_nec_tx #(
    .CLK_PER_TICK(CPT),
    .CARRIER_HALF(CH),
    .GAP_TICKS(GAP)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_addr (tx_addr),
    .tx_cmd  (tx_cmd),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .ir_out  (ir_out),
    .ir_mod  (ir_mod)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // advance one clock, sample 1 time unit after the edge, track carrier phase
  task automatic step();
    logic em;
    @(posedge clk_in);
    #1;
    if (!rst_n) edge_cnt = 0;
    else edge_cnt++;
    em = ir_out & (((edge_cnt / CH) % 2) == 1);
    if (ir_mod !== em) mod_errs++;
  endtask

  // expected alternating mark/space run lengths in cycles, starting with a mark
  function automatic void build_expected(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] bytes[4];
    int b;
    bytes[0] = a;
    bytes[1] = ~a;
    bytes[2] = c;
    bytes[3] = ~c;
    exp_q.delete();
    exp_q.push_back(256 * CPT);
    exp_q.push_back(128 * CPT);
    for (int i = 0; i < 32; i++) begin
      b = (int'(bytes[i / 8]) >> (i % 8)) & 1;
      exp_q.push_back(16 * CPT);
      exp_q.push_back((b == 1 ? 48 : 16) * CPT);
    end
    exp_q.push_back(16 * CPT);
    exp_q.push_back(GAP * CPT);
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c,
                            input bit spam, input bit start_at_done,
                            output logic [7:0] dec_a, output logic [7:0] dec_c);
    int total, k, run, done_k, busy_err, mod0, bad;
    logic cur, first;
    bit seen;
    logic [31:0] word;
    build_expected(a, c);
    total = 0;
    foreach (exp_q[i]) total += exp_q[i];
    meas_q.delete();
    mod0 = mod_errs;
    busy_err = 0;
    seen = 0;
    done_k = -1;
    tx_addr = a;
    tx_cmd = c;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    tx_addr = 8'($urandom);
    tx_cmd = 8'($urandom);
    first = ir_out;
    cur = ir_out;
    run = 0;
    for (k = 0; k <= total + 20; k++) begin
      if (k > 0) step();
      tx_start = 1'b0;
      if (tx_done) begin
        seen = 1;
        done_k = k;
        break;
      end
      if (spam && (k % 300) == 150) begin
        tx_start = 1'b1;
        tx_addr = 8'($urandom);
        tx_cmd = 8'($urandom);
      end
      if (!tx_busy) busy_err++;
      if (ir_out == cur) run++;
      else begin
        meas_q.push_back(run);
        cur = ir_out;
        run = 1;
      end
    end
    if (run > 0) meas_q.push_back(run);
    check("first_level", longint'(first), 1);
    check("done_seen", longint'(seen), 1);
    check("done_cycle", done_k, total);
    check("busy_in_frame", busy_err, 0);
    check("busy_at_done", longint'(tx_busy), 0);
    check("run_count", meas_q.size(), exp_q.size());
    bad = -1;
    foreach (exp_q[i]) begin
      if (bad < 0 && (i >= meas_q.size() || meas_q[i] != exp_q[i])) bad = i;
    end
    check("run_mismatch_idx", bad, -1);
    // receiver: long space decodes as 1
    word = '0;
    if (meas_q.size() >= 67) begin
      for (int i = 0; i < 32; i++) word[i] = (meas_q[3 + 2 * i] > 32 * CPT);
    end
    dec_a = word[7:0];
    dec_c = word[23:16];
    tx_start = start_at_done;
    if (start_at_done) begin
      tx_addr = 8'($urandom);
      tx_cmd = 8'($urandom);
    end
    step();
    tx_start = 1'b0;
    check("done_pulse_width", longint'(tx_done), 0);
    check("busy_after_done", longint'(tx_busy), 0);
    check("ir_out_after_done", longint'(ir_out), 0);
    check("ir_mod_errs", mod_errs - mod0, 0);
  endtask

  initial begin
    logic [7:0] da, dc, ra, rc;
    vecs[0] = '{8'h00, 8'h45, 8'h00, 8'h45};
    vecs[1] = '{8'h00, 8'hA5, 8'h00, 8'hA5};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{8'h5A, 8'h3C, 8'h5A, 8'h3C};

    rst_n = 1'b0;
    tx_start = 1'b1;
    repeat (3) step();
    check("rst_ir_out", longint'(ir_out), 0);
    check("rst_ir_mod", longint'(ir_mod), 0);
    check("rst_busy", longint'(tx_busy), 0);
    check("rst_done", longint'(tx_done), 0);
    tx_start = 1'b0;
    rst_n = 1'b1;
    repeat (10) step();
    check("idle_busy", longint'(tx_busy), 0);

    foreach (vecs[i]) begin
      send_frame(vecs[i].addr, vecs[i].cmd, 1'b0, 1'b0, da, dc);
      check("dec_addr", da, vecs[i].exp_a);
      check("dec_cmd", dc, vecs[i].exp_c);
      repeat (3) step();
    end

    // repeated start requests during a frame are ignored
    send_frame(8'h12, 8'h34, 1'b1, 1'b0, da, dc);
    check("spam_dec_addr", da, 8'h12);
    check("spam_dec_cmd", dc, 8'h34);
    repeat (20) step();
    check("spam_no_second_frame", longint'(tx_busy), 0);

    // start in the done cycle is ignored
    send_frame(8'h80, 8'h01, 1'b0, 1'b1, da, dc);
    check("done_start_dec_cmd", dc, 8'h01);
    repeat (10) step();
    check("no_start_from_done", longint'(tx_busy), 0);

    // reset during bit 10, then a fresh full frame
    tx_addr = 8'h00;
    tx_cmd = 8'h45;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat ((384 + 8 * 32 + 2 * 64) * CPT + 20) step();
    check("busy_before_reset", longint'(tx_busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ir_out", longint'(ir_out), 0);
    check("midrst_ir_mod", longint'(ir_mod), 0);
    check("midrst_busy", longint'(tx_busy), 0);
    check("midrst_done", longint'(tx_done), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) step();
    check("no_frame_after_reset", longint'(tx_busy), 0);
    check("low_after_reset", longint'(ir_out), 0);
    send_frame(8'h00, 8'h45, 1'b0, 1'b0, da, dc);
    check("postrst_dec_addr", da, 8'h00);
    check("postrst_dec_cmd", dc, 8'h45);

    repeat (4) begin
      ra = 8'($urandom);
      rc = 8'($urandom);
      repeat ($urandom_range(1, 7)) step();
      send_frame(ra, rc, 1'b0, 1'b0, da, dc);
      check("rand_dec_addr", da, ra);
      check("rand_dec_cmd", dc, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
